// File: rtl/core_select_ctrl.sv
// rtl/core_select_ctrl.sv - heartbeat watchdogs and A/B output-select FSM with dwell and force override
module core_select_ctrl #(
    parameter int TIMEOUT = 1000,
    parameter int REVIVE  = 4,
    parameter int DWELL   = 256,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic hb_a,
    input  logic hb_b,
    input  logic force_en,
    input  logic force_sel,
    output logic ctr_io,
    output logic a_alive,
    output logic b_alive,
    output logic switch_pulse
);
    localparam int RV_W = $clog2(REVIVE + 1);
    localparam logic [CNT_W-1:0] TMO_MAX   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL);
    localparam logic [RV_W-1:0]  REV_LAST  = RV_W'(REVIVE - 1);

    typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} state_t;

    // Bit [1] of each synchroniser is the usable, metastability-filtered value.
    logic [1:0] sync_a_q, sync_b_q, sync_fe_q, sync_fs_q;
    // Previous synced heartbeat samples, [0] = A, [1] = B.
    logic [1:0] prev_q;
    logic [1:0] beat;
    logic       force_s, fsel_s;

    // Per-core watchdog state, index 0 = A, index 1 = B.
    logic [1:0][CNT_W-1:0] wd_q, wd_d;
    logic [1:0][RV_W-1:0]  rv_q, rv_d;
    logic [1:0]            alive_q, alive_d;

    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             dwell_ok;
    state_t           state_q, state_d;
    logic             pulse_q;

    // Synchronise all asynchronous inputs and remember the last heartbeat sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_q  <= '0;
            sync_b_q  <= '0;
            sync_fe_q <= '0;
            sync_fs_q <= '0;
            prev_q    <= '0;
        end else begin
            sync_a_q  <= {sync_a_q[0], hb_a};
            sync_b_q  <= {sync_b_q[0], hb_b};
            sync_fe_q <= {sync_fe_q[0], force_en};
            sync_fs_q <= {sync_fs_q[0], force_sel};
            prev_q    <= {sync_b_q[1], sync_a_q[1]};
        end
    end

    assign beat     = {sync_b_q[1], sync_a_q[1]} ^ prev_q;
    assign force_s  = sync_fe_q[1];
    assign fsel_s   = sync_fs_q[1];
    assign dwell_ok = (dwell_q == DWELL_MAX);

    // Watchdog per core: a beat clears the timer and counts toward revival; expiry kills the core
    always_comb begin
        wd_d    = wd_q;
        rv_d    = rv_q;
        alive_d = alive_q;
        for (int c = 0; c < 2; c++) begin
            if (beat[c]) begin
                wd_d[c] = '0;
                if (!alive_q[c]) begin
                    if (rv_q[c] == REV_LAST) begin
                        alive_d[c] = 1'b1;
                        rv_d[c]    = '0;
                    end else begin
                        rv_d[c] = rv_q[c] + 1'b1;
                    end
                end
            end else if (wd_q[c] != TMO_MAX) begin
                wd_d[c] = wd_q[c] + 1'b1;
                if (wd_q[c] == TMO_LAST) begin
                    alive_d[c] = 1'b0;
                    rv_d[c]    = '0;
                end
            end
        end
    end

    // Select FSM next state: force first, then health-driven failover gated by dwell
    always_comb begin
        state_d = state_q;
        if (force_s) begin
            if (state_t'(fsel_s) != state_q) begin
                state_d = state_t'(fsel_s);
            end
        end else if (state_q == SEL_A) begin
            if (!alive_q[0] && alive_q[1] && dwell_ok) begin
                state_d = SEL_B;
            end
        end else begin
            if (!alive_q[1] && alive_q[0] && dwell_ok) begin
                state_d = SEL_A;
            end
        end
    end

    // Dwell timer restarts on every switch and saturates once the minimum dwell is met
    always_comb begin
        dwell_d = dwell_q;
        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (!dwell_ok) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    // State register: FSM, watchdogs, dwell timer and the switch pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEL_A;
            wd_q    <= '0;
            rv_q    <= '0;
            alive_q <= 2'b11;
            dwell_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            rv_q    <= rv_d;
            alive_q <= alive_d;
            dwell_q <= dwell_d;
            pulse_q <= (state_d != state_q);
        end
    end

    // Outputs come straight from registers; ctr_io is the FSM state itself
    always_comb begin
        ctr_io       = (state_q == SEL_B);
        a_alive      = alive_q[0];
        b_alive      = alive_q[1];
        switch_pulse = pulse_q;
    end

endmodule
